// File: rtl/fb_pkg.sv
// Shared definitions for the serial 16-channel FIR filterbank: schedule
// constants, sample/output widths and the sequencer state encoding.
package fb_pkg;

    localparam int FB_NUM_TAPS = 119;
    localparam int FB_PHASES   = (FB_NUM_TAPS + 1) / 2;
    localparam int FB_NUM_CH   = 16;
    localparam int FB_IDX_W    = 6;
    localparam int FB_IN_W     = 14;
    localparam int FB_OUT_W    = 35;

    typedef logic signed [FB_IN_W-1:0]  fb_sample_t;
    typedef logic signed [FB_OUT_W-1:0] fb_out_t;
    typedef fb_out_t                    fb_out_bank_t [FB_NUM_CH];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAP  = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_phase_counter.sv
// Tap-pair index counter: synchronous clear, qualified advance, and a
// terminal-count flag at which it parks until the next clear.
module fb_phase_counter
    import fb_pkg::*;
#(
    parameter int PHASES = FB_PHASES,
    parameter int IDX_W  = FB_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_adv && !o_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/fb_serial_sequencer.sv
// Back-pressurable MAC schedule for the serial filterbank: accept, run
// PHASES tap-pair cycles, optionally wait for downstream, then capture.
// Optional dropped-input counter is built when FB_SEQ_OVERRUN_EN is defined.
module fb_serial_sequencer
    import fb_pkg::*;
#(
    parameter int PHASES = FB_PHASES,
    parameter int IDX_W  = FB_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic [IDX_W-1:0] phase_idx,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             out_capture,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       overrun_cnt
);

    fb_state_e r_state;
    fb_state_e w_state_next;

    logic r_shift_en;
    logic r_acc_clear;
    logic r_acc_en;
    logic r_out_capture;
    logic r_out_valid;
    logic w_last_phase;
    logic w_accept;
    logic w_cnt_adv;
    logic w_out_free;

    assign w_accept   = (r_state == ST_IDLE) && in_valid && clk_enable;
    assign w_cnt_adv  = clk_enable && (r_state == ST_RUN);
    assign w_out_free = !r_out_valid || out_ready;

    fb_phase_counter #(
        .PHASES (PHASES),
        .IDX_W  (IDX_W)
    ) u_phase_counter (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_accept),
        .i_adv  (w_cnt_adv),
        .o_idx  (phase_idx),
        .o_last (w_last_phase)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_last_phase) w_state_next = w_out_free ? ST_CAP : ST_WAIT;
            ST_WAIT: if (w_out_free) w_state_next = ST_CAP;
            ST_CAP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (clk_enable) begin
            r_state <= w_state_next;
        end
    end

    // Strobe registers freeze with the state, so an action pending across a
    // frozen cycle still fires exactly once on the next enabled cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift_en    <= 1'b0;
            r_acc_clear   <= 1'b0;
            r_acc_en      <= 1'b0;
            r_out_capture <= 1'b0;
            r_out_valid   <= 1'b0;
        end else if (clk_enable) begin
            r_shift_en    <= (r_state == ST_IDLE) && (w_state_next == ST_RUN);
            r_acc_clear   <= (r_state == ST_IDLE) && (w_state_next == ST_RUN);
            r_acc_en      <= (w_state_next == ST_RUN);
            r_out_capture <= (w_state_next == ST_CAP);
            if (w_state_next == ST_CAP) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign shift_en    = r_shift_en    && clk_enable;
    assign acc_clear   = r_acc_clear   && clk_enable;
    assign acc_en      = r_acc_en      && clk_enable;
    assign out_capture = r_out_capture && clk_enable;
    assign out_valid   = r_out_valid;

`ifdef FB_SEQ_OVERRUN_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun_cnt <= 8'd0;
        end else if (clk_enable && in_valid && (r_state == ST_WAIT) && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fb_serial_sequencer.sv
// Self-checking bench for fb_serial_sequencer: reset/table vectors, directed
// schedule corner cases, and randomized traffic against a sample-level model.
module tb_fb_serial_sequencer;
    import fb_pkg::*;

    localparam int PH = 60;

    logic       clock = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic       in_valid;
    logic       in_ready;
    logic       shift_en;
    logic [5:0] phase_idx;
    logic       acc_clear;
    logic       acc_en;
    logic       out_capture;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] overrun_cnt;

    always #5 clock = ~clock;

    fb_serial_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift_en    (shift_en),
        .phase_idx   (phase_idx),
        .acc_clear   (acc_clear),
        .acc_en      (acc_en),
        .out_capture (out_capture),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_cnt (overrun_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference: a sample in flight and how many of its MAC cycles are done.
    bit m_busy, m_cap, m_ov;
    int m_macs, m_phase, m_ovr;

    // Observations of the cycle most recently completed by tick().
    bit s_acc, s_shift, s_clr, s_acc_en, s_cap, s_ov, s_rdy;
    int s_ph, s_cyc, s_ovr;

    typedef struct {
        bit rst, en, iv, ordy;
        bit e_rdy, e_shift, e_clr, e_acc, e_cap, e_ov;
        int e_ph;
    } vec_t;
    vec_t tbl [8];

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_cap = 0; m_ov = 0;
        m_macs = 0; m_phase = 0; m_ovr = 0;
    endfunction

    function automatic void model_compare();
        bit running;
        running = m_busy && !m_cap && (m_macs < PH);
        chk("in_ready",    in_ready,    !m_busy);
        chk("shift_en",    shift_en,    running && (m_macs == 0) && clk_enable);
        chk("acc_clear",   acc_clear,   running && (m_macs == 0) && clk_enable);
        chk("acc_en",      acc_en,      running && clk_enable);
        chk("out_capture", out_capture, m_cap && clk_enable);
        chk("out_valid",   out_valid,   m_ov);
        chk("phase_idx",   phase_idx,   m_phase);
        chk("overrun_cnt", overrun_cnt, m_ovr);
    endfunction

    function automatic void model_step();
        bit waiting, go, newcap;
        if (reset) begin
            model_reset();
            return;
        end
        if (!clk_enable) return;
        waiting = m_busy && !m_cap && (m_macs == PH);
        go      = !m_ov || out_ready;
        newcap  = 0;
`ifdef FB_SEQ_OVERRUN_EN
        if (waiting && in_valid && m_ovr < 255) m_ovr++;
`endif
        if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_macs = 0; m_phase = 0;
                $display("[%0d] sample accepted", cyc);
            end
        end else if (m_cap) begin
            m_busy = 0; m_cap = 0;
        end else if (m_macs < PH) begin
            m_macs++;
            if (m_macs == PH) newcap = go;
            else m_phase = m_macs;
        end else begin
            newcap = go;
        end
        if (m_ov && out_ready) m_ov = 0;
        if (newcap) begin
            m_cap = 1; m_ov = 1;
            $display("[%0d] result capture scheduled", cyc);
        end
    endfunction

    task automatic tick();
        #1;
        s_acc = in_ready && in_valid && clk_enable;
        s_shift = shift_en; s_clr = acc_clear; s_acc_en = acc_en; s_cap = out_capture;
        s_ov = out_valid; s_rdy = in_ready; s_ph = phase_idx; s_ovr = overrun_cnt; s_cyc = cyc;
        model_compare();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int t_acc, t_shift, t_59, t_cap, t_rdy, ov_at_cap, n_caps, n_shift, found;
        int acc_times[$];
        int phases[$];

        reset = 1; clk_enable = 1; in_valid = 0; out_ready = 0;
        model_reset();
        @(posedge clock); #1;
        tick(); tick();
        reset = 0;

        // ---------------- table-driven vectors ----------------
        tbl[0] = '{0,1,0,0, 1,0,0,0,0,0, 0};
        tbl[1] = '{0,1,1,0, 1,0,0,0,0,0, 0};
        tbl[2] = '{0,1,1,0, 0,1,1,1,0,0, 0};
        tbl[3] = '{0,0,1,0, 0,0,0,0,0,0, 1};
        tbl[4] = '{0,1,0,0, 0,0,0,1,0,0, 1};
        tbl[5] = '{0,1,0,0, 0,0,0,1,0,0, 2};
        tbl[6] = '{1,1,0,0, 0,0,0,1,0,0, 3};
        tbl[7] = '{0,1,0,0, 1,0,0,0,0,0, 0};
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; clk_enable = tbl[i].en;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_shift_en", i), shift_en, tbl[i].e_shift);
            chk($sformatf("vec%0d_acc_clear", i), acc_clear, tbl[i].e_clr);
            chk($sformatf("vec%0d_acc_en", i), acc_en, tbl[i].e_acc);
            chk($sformatf("vec%0d_out_capture", i), out_capture, tbl[i].e_cap);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d_phase_idx", i), phase_idx, tbl[i].e_ph);
            $display("[%0d] vector %0d applied", cyc, i);
            tick();
        end
        reset = 0; clk_enable = 1; in_valid = 0;

        // ---------------- reset in the middle of RUN ----------------
        in_valid = 1; out_ready = 1; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (s_acc_en && s_ph == 29) found = 1;
        end
        chk("midrun_reach_phase29", found, 1);
        reset = 1;
        tick();
        chk("midrun_phase_at_reset", s_ph, 30);
        reset = 0; in_valid = 0;
        tick();
        chk("midrun_in_ready_after", s_rdy, 1);
        chk("midrun_phase_after", s_ph, 0);
        n_caps = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (s_cap) n_caps++;
        end
        chk("midrun_no_capture", n_caps, 0);
        $display("[%0d] mid-run reset sequence done", cyc);

        // ---------------- single sample latency ----------------
        in_valid = 1; out_ready = 1;
        t_acc = -1; t_shift = -1; t_59 = -1; t_cap = -1; t_rdy = -1; ov_at_cap = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (t_acc >= 0 && s_cyc > t_acc) begin
                if (s_shift && s_clr && t_shift < 0) t_shift = s_cyc;
                if (s_ph == PH - 1 && t_59 < 0) t_59 = s_cyc;
                if (s_cap && t_cap < 0) begin t_cap = s_cyc; ov_at_cap = s_ov; end
                if (t_cap >= 0 && s_cyc > t_cap && s_rdy && t_rdy < 0) t_rdy = s_cyc;
            end
            if (s_acc && t_acc < 0) begin t_acc = s_cyc; in_valid = 0; end
        end
        chk("single_shift_latency", t_shift - t_acc, 1);
        chk("single_phase59_latency", t_59 - t_acc, PH);
        chk("single_capture_latency", t_cap - t_acc, PH + 1);
        chk("single_ready_latency", t_rdy - t_acc, PH + 2);
        chk("single_valid_at_capture", ov_at_cap, 1);

        // ---------------- back-to-back samples ----------------
        in_valid = 1; out_ready = 1; n_shift = 0;
        acc_times.delete();
        for (int i = 0; i < 4 * (PH + 2) + 5; i++) begin
            tick();
            if (s_acc) acc_times.push_back(s_cyc);
            if (s_shift) n_shift++;
        end
        chk("b2b_accept_count", acc_times.size(), 5);
        for (int k = 1; k < acc_times.size(); k++)
            chk($sformatf("b2b_interval%0d", k), acc_times[k] - acc_times[k-1], PH + 2);
        chk("b2b_shift_per_accept", n_shift, acc_times.size());
        in_valid = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (s_rdy) found = 1;
        end
        chk("b2b_drain", found, 1);

        // ---------------- downstream stall, WAIT, overrun ----------------
        out_ready = 0; in_valid = 1; found = 0;
        for (int i = 0; i < 250 && !found; i++) begin
            tick();
            if (!s_rdy && !s_acc_en && !s_cap && s_ph == PH - 1) found = 1;
        end
        chk("stall_reach_wait", found, 1);
        for (int i = 0; i < 300; i++) tick();
        chk("stall_phase_holds", s_ph, PH - 1);
        chk("stall_acc_en_low", s_acc_en, 0);
        chk("stall_in_ready_low", s_rdy, 0);
`ifdef FB_SEQ_OVERRUN_EN
        chk("stall_overrun_saturated", s_ovr, 255);
`else
        chk("stall_overrun_zero", s_ovr, 0);
`endif
        out_ready = 1;
        tick();
        chk("stall_no_capture_at_x", s_cap, 0);
        tick();
        chk("stall_capture_at_x_plus_1", s_cap, 1);
        chk("stall_valid_set_wins", s_ov, 1);
        in_valid = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (s_rdy && !s_ov) found = 1;
        end
        chk("stall_drain", found, 1);
        $display("[%0d] stall sequence done", cyc);

        // ---------------- clk_enable toggling ----------------
        in_valid = 1; out_ready = 1; clk_enable = 1;
        tick();
        chk("toggle_accept", s_acc, 1);
        t_acc = s_cyc; in_valid = 0; t_cap = -1; n_shift = 0;
        phases.delete();
        for (int i = 1; i <= 140; i++) begin
            clk_enable = (i % 2 == 0);
            tick();
            if (s_acc_en) phases.push_back(s_ph);
            if (s_shift) n_shift++;
            if (s_cap && t_cap < 0) t_cap = s_cyc;
        end
        clk_enable = 1;
        chk("toggle_mac_count", phases.size(), PH);
        for (int k = 0; k < phases.size(); k++)
            chk($sformatf("toggle_phase%0d", k), phases[k], k);
        chk("toggle_shift_once", n_shift, 1);
        chk("toggle_capture_latency", t_cap - t_acc, 2 * (PH + 1));

        // ---------------- randomized traffic against the model ----------------
        for (int i = 0; i < 4000; i++) begin
            clk_enable = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 1) == 1);
            out_ready  = ($urandom_range(0, 2) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_serial_sequencer.md
Name: fb_serial_sequencer

Overview:
Sequencing controller for the serial 16-channel FIR filterbank. It accepts one input sample per handshake and pulses the delay-line shift strobe once per accepted sample. It then steps the shared coefficient/tap-pair index through PHASES MAC cycles, drives accumulator clear/enable, and raises a capture strobe plus output valid/ready handshake for the 16 filter outputs. It replaces free-running phase decoding with an explicit, back-pressurable schedule.

Parameters:
NUM_TAPS, 119, delay-line length served by the filters
PHASES, 60, MAC cycles per sample (ceil(NUM_TAPS/2), symmetric tap pairs)
IDX_W, 6, width of phase_idx; must satisfy 2**IDX_W >= PHASES

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
clk_enable  in  1  global advance qualifier; low freezes all state
in_valid  in  1  new sample present on filter_in
in_ready  out  1  sequencer can accept a sample
shift_en  out  1  one-cycle strobe: shift delay line, load filter_in
phase_idx  out  IDX_W  current tap-pair/coefficient index
acc_clear  out  1  clear accumulators (coincides with phase 0)
acc_en  out  1  accumulate this cycle
out_capture  out  1  one-cycle strobe: latch accumulators into output regs
out_valid  out  1  filter_out bank holds unconsumed result
out_ready  in  1  downstream consumes result
overrun_cnt  out  8  dropped-sample count (see Optional Feature)

Behaviour:
- Reset is synchronous: all outputs 0 except in_ready=1; state IDLE; phase_idx=0; out_valid=0. Reset mid-sample aborts the sample with no capture.
- States: IDLE, RUN, WAIT, CAP. All strobes are registered. in_ready = (state==IDLE), decoded from state.
- clk_enable=0: state, counter and out_valid hold. shift_en, acc_clear, acc_en and out_capture are forced 0 that cycle. Acceptance requires clk_enable=1.
- IDLE: acceptance at cycle T (in_valid & in_ready & clk_enable). At T+1: state RUN, shift_en=1, acc_clear=1, acc_en=1, phase_idx=0.
- RUN: acc_en=1; phase_idx increments each enabled cycle: 0..PHASES-1, occupying T+1..T+PHASES. After the phase_idx=PHASES-1 cycle:
  - out_valid=0, or out_ready=1 in that cycle: go to CAP.
  - otherwise: go to WAIT.
- WAIT: acc_en=0; phase_idx holds at PHASES-1; accumulators are untouched. Go to CAP the cycle after out_ready=1 or out_valid=0.
- CAP: out_capture=1 and out_valid<=1 for one cycle, then IDLE. With no stall, capture is at T+PHASES+1 and in_ready=1 again at T+PHASES+2. Throughput is one sample per PHASES+2 cycles.
- out_valid: set by CAP, cleared by out_valid & out_ready. If set and clear occur in the same cycle, set wins.
- in_valid outside IDLE is not accepted; the source must hold the sample until in_ready.
- phase_idx never exceeds PHASES-1; it wraps to 0 only via a new acceptance.

Optional Feature:
Macro FB_SEQ_OVERRUN_EN.
- Defined: 8-bit saturating overrun_cnt increments each enabled cycle with in_valid=1 and in_ready=0 while state is WAIT (downstream stall blocking input). It clears only on reset and saturates at 255.
- Undefined: overrun_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package fb_pkg: state enum (IDLE, RUN, WAIT, CAP), FB_NUM_TAPS=119, FB_PHASES=60, FB_NUM_CH=16, IDX_W, and the sample/output width typedefs (14-bit input, 35-bit output).
- One natural sub-module: fb_phase_counter (enable/clear/terminal-count counter, emits last_phase). The FSM stays in fb_serial_sequencer.

Test Plan:
- Reset mid-RUN at phase_idx=30: next cycle state IDLE, in_ready=1, phase_idx=0; out_capture never pulses.
- Single sample, out_ready=1 constant, accepted at cycle 10: shift_en and acc_clear at 11; phase_idx=59 at 70; out_capture and out_valid at 71; in_ready at 72.
- Back-to-back samples, in_valid held high: accepted every 62 cycles; exactly one shift_en per acceptance.
- out_ready=0 with out_valid already set at end of RUN: enters WAIT, acc_en=0, phase_idx holds at 59. Raise out_ready at cycle X: out_capture at X+1; out_valid stays 1 (set wins).
- clk_enable toggled 1/0 every cycle during RUN: phase sequence still 0..59 with no skipped or repeated index; capture takes 2x cycles.
- FB_SEQ_OVERRUN_EN defined, in_valid held high through a 300-cycle WAIT: overrun_cnt saturates at 255. Undefined: overrun_cnt stays 0.
